// File: rtl/basys3_display_pkg.sv
// Shared constants for the Basys3 multiplexed 7-segment display path.
// The encoder on the driving side and the capture decoder both use these patterns.
package basys3_display_pkg;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [3:0] ANODE_DIG0 = 4'b1110;
  localparam logic [3:0] ANODE_DIG1 = 4'b1101;
  localparam logic [3:0] ANODE_DIG2 = 4'b1011;
  localparam logic [3:0] ANODE_DIG3 = 4'b0111;

  function automatic logic anode_is_single(input logic [3:0] an);
    case (an)
      ANODE_DIG0, ANODE_DIG1, ANODE_DIG2, ANODE_DIG3: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] anode_index(input logic [3:0] an);
    case (an)
      ANODE_DIG1: return 2'd1;
      ANODE_DIG2: return 2'd2;
      ANODE_DIG3: return 2'd3;
      default:    return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/basys3_display_capture_seg7_to_hex.sv
// Combinational active-low 7-segment to hex decoder.
// Patterns outside the sixteen hex glyphs report valid = 0.
module seg7_to_hex
  import basys3_display_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       valid
);

  always_comb begin
    hex   = 4'h0;
    valid = 1'b1;
    case (seg)
      SEG_0: hex = 4'h0;
      SEG_1: hex = 4'h1;
      SEG_2: hex = 4'h2;
      SEG_3: hex = 4'h3;
      SEG_4: hex = 4'h4;
      SEG_5: hex = 4'h5;
      SEG_6: hex = 4'h6;
      SEG_7: hex = 4'h7;
      SEG_8: hex = 4'h8;
      SEG_9: hex = 4'h9;
      SEG_A: hex = 4'hA;
      SEG_B: hex = 4'hB;
      SEG_C: hex = 4'hC;
      SEG_D: hex = 4'hD;
      SEG_E: hex = 4'hE;
      SEG_F: hex = 4'hF;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/basys3_display_capture.sv
// Rebuilds four hex digits from a sampled multiplexed anode/segment bus, with
// debounce, per-digit validity, frame-complete, decode-error and staleness flags.
module basys3_display_capture
  import basys3_display_pkg::*;
#(
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       disp_clk,
  input  logic       reset,
  input  logic [3:0] anodes_in,
  input  logic [6:0] segments_in,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic [3:0] digit_valid,
  output logic       frame_done,
  output logic       seg_error,
  output logic       stale
);

  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);

  logic [3:0]    s_an_q, p_an_q;
  logic [6:0]    s_seg_q, p_seg_q;
  logic [RW-1:0] run_q, run_d;
  logic [TW-1:0] to_q, to_d;
  logic [3:0]    valid_q, valid_d;
  logic [3:0]    mask_q, mask_d;
  logic          stale_q, stale_d;
  logic          frame_done_q, seg_error_q;

  logic          an_ok, same, commit, expire, frame_hit;
  logic [1:0]    idx;
  logic [3:0]    hex;
  logic          hex_ok;

  seg7_to_hex u_dec (
    .seg   (s_seg_q),
    .hex   (hex),
    .valid (hex_ok)
  );

  assign an_ok = anode_is_single(s_an_q);
  assign idx   = anode_index(s_an_q);
  assign same  = ({s_an_q, s_seg_q} == {p_an_q, p_seg_q});

  always_comb begin
    run_d = '0;
    if (an_ok) begin
      if (!same)
        run_d = RW'(1);
      else if (run_q == RUN_MAX)
        run_d = run_q;
      else
        run_d = run_q + 1'b1;
    end
  end

  // A saturated run that stays the same must not commit a second time.
  assign commit    = an_ok && (run_d == RUN_MAX) && !(same && (run_q == RUN_MAX));
  assign frame_hit = commit && hex_ok && (idx == 2'd0) && ((mask_q | 4'b0001) == 4'b1111);

  always_comb begin
    to_d = '0;
    if (!commit)
      to_d = (to_q == TO_MAX) ? to_q : to_q + 1'b1;
  end

  assign expire = !commit && (to_d == TO_MAX);

  always_comb begin
    mask_d  = mask_q;
    valid_d = valid_q;
    stale_d = stale_q;
    if (commit) begin
      stale_d = 1'b0;
      if (hex_ok) begin
        valid_d[idx] = 1'b1;
        mask_d[idx]  = 1'b1;
        if (frame_hit)
          mask_d = 4'b0000;
      end else begin
        valid_d[idx] = 1'b0;
        mask_d[idx]  = 1'b0;
      end
    end else if (expire) begin
      stale_d = 1'b1;
      valid_d = 4'b0000;
      mask_d  = 4'b0000;
    end
  end

  always_ff @(posedge disp_clk) begin
    if (!reset) begin
      s_an_q       <= '0;
      s_seg_q      <= '0;
      p_an_q       <= '0;
      p_seg_q      <= '0;
      run_q        <= '0;
      to_q         <= '0;
      valid_q      <= '0;
      mask_q       <= '0;
      stale_q      <= 1'b1;
      frame_done_q <= 1'b0;
      seg_error_q  <= 1'b0;
    end else begin
      s_an_q       <= anodes_in;
      s_seg_q      <= segments_in;
      p_an_q       <= s_an_q;
      p_seg_q      <= s_seg_q;
      run_q        <= run_d;
      to_q         <= to_d;
      valid_q      <= valid_d;
      mask_q       <= mask_d;
      stale_q      <= stale_d;
      frame_done_q <= frame_hit;
      seg_error_q  <= commit && !hex_ok;
    end
  end

  // Digit values survive timeouts and invalid commits; only a good commit replaces them.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dig
      logic [3:0] dig_q;
      always_ff @(posedge disp_clk) begin
        if (!reset)
          dig_q <= 4'h0;
        else if (commit && hex_ok && (idx == 2'(gi)))
          dig_q <= hex;
      end
    end
  endgenerate

  assign dig0        = g_dig[0].dig_q;
  assign dig1        = g_dig[1].dig_q;
  assign dig2        = g_dig[2].dig_q;
  assign dig3        = g_dig[3].dig_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_done_q;
  assign seg_error   = seg_error_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_basys3_display_capture.sv
// Randomised and directed bench for basys3_display_capture with a run-length
// reference model feeding a per-cycle scoreboard.
module tb_basys3_display_capture;

  localparam int STABLE  = 2;
  localparam int TIMEOUT = 1024;

  logic       disp_clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] anodes_in = 4'hF;
  logic [6:0] segments_in = 7'h7F;
  logic [3:0] dig3, dig2, dig1, dig0, digit_valid;
  logic       frame_done, seg_error, stale;

  always #5 disp_clk = ~disp_clk;

  basys3_display_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .disp_clk    (disp_clk),
    .reset       (reset),
    .anodes_in   (anodes_in),
    .segments_in (segments_in),
    .dig3        (dig3),
    .dig2        (dig2),
    .dig1        (dig1),
    .dig0        (dig0),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .seg_error   (seg_error),
    .stale       (stale)
  );

  typedef struct {
    logic [3:0] d3, d2, d1, d0, valid;
    logic       fd, se, st;
    bit         commit;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state
  int          m_len;
  logic [10:0] m_last;
  bit          m_pend;
  logic [3:0]  m_dig [4];
  logic [3:0]  m_valid, m_mask;
  logic        m_stale;
  int          m_since;

  function automatic int an_index(input logic [3:0] an);
    int zeros = 0;
    int pos = -1;
    for (int b = 0; b < 4; b++)
      if (an[b] == 1'b0) begin
        zeros++;
        pos = b;
      end
    return (zeros == 1) ? pos : -1;
  endfunction

  function automatic int decode(input logic [6:0] s);
    for (int v = 0; v < 16; v++)
      if (seg_tab[v] == s) return v;
    return -1;
  endfunction

  task automatic model_reset();
    m_len = 0; m_last = '0; m_pend = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
    m_valid = 4'h0; m_mask = 4'h0; m_stale = 1'b1; m_since = 0;
  endtask

  task automatic step(input logic rst_n, input logic [3:0] an, input logic [6:0] sg);
    exp_t e;
    int   idx, h;
    @(negedge disp_clk);
    reset = rst_n; anodes_in = an; segments_in = sg;
    e.fd = 1'b0; e.se = 1'b0; e.commit = 0;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_pend) begin
        idx = an_index(m_last[10:7]);
        h   = decode(m_last[6:0]);
        e.commit = 1;
        m_since = 0; m_stale = 1'b0;
        if (h >= 0) begin
          m_dig[idx] = 4'(h);
          m_valid[idx] = 1'b1;
          m_mask[idx] = 1'b1;
          if (idx == 0 && m_mask == 4'hF) begin
            e.fd = 1'b1;
            m_mask = 4'h0;
          end
        end else begin
          m_valid[idx] = 1'b0;
          m_mask[idx] = 1'b0;
          e.se = 1'b1;
        end
      end else begin
        if (m_since < TIMEOUT) m_since++;
        if (m_since >= TIMEOUT) begin
          m_stale = 1'b1; m_valid = 4'h0; m_mask = 4'h0;
        end
      end
      if (an_index(an) >= 0) begin
        if ({an, sg} == m_last && m_len > 0) m_len = (m_len > STABLE) ? m_len : m_len + 1;
        else m_len = 1;
      end else begin
        m_len = 0;
      end
      m_last = {an, sg};
      m_pend = (m_len == STABLE);
    end
    e.d3 = m_dig[3]; e.d2 = m_dig[2]; e.d1 = m_dig[1]; e.d0 = m_dig[0];
    e.valid = m_valid; e.st = m_stale;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge
  exp_t me;
  always @(posedge disp_clk) begin
    #1;
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      chk("dig3", dig3, me.d3);
      chk("dig2", dig2, me.d2);
      chk("dig1", dig1, me.d1);
      chk("dig0", dig0, me.d0);
      chk("digit_valid", digit_valid, me.valid);
      chk("frame_done", {3'b0, frame_done}, {3'b0, me.fd});
      chk("seg_error", {3'b0, seg_error}, {3'b0, me.se});
      chk("stale", {3'b0, stale}, {3'b0, me.st});
      if (me.commit)
        $display("commit t=%0t dig=%h%h%h%h valid=%b frame_done=%b seg_error=%b stale=%b",
                 $time, dig3, dig2, dig1, dig0, digit_valid, frame_done, seg_error, stale);
    end
  end

  task automatic frame(input int d3, input int d2, input int d1, input int d0, input int hold);
    int d [4];
    logic [3:0] an;
    d[3] = d3; d[2] = d2; d[1] = d1; d[0] = d0;
    for (int p = 3; p >= 0; p--) begin
      an = ~(4'b0001 << p);
      repeat (hold) step(1'b1, an, seg_tab[d[p]]);
    end
  endtask

  initial begin
    logic [3:0] an;
    logic [6:0] sg;
    int a, b, hold;
    model_reset();
    repeat (3) step(1'b0, 4'hF, 7'h7F);
    // Blank bus: nothing commits, stays stale
    repeat (2000) step(1'b1, 4'hF, 7'h7F);
    // Normal rotation
    repeat (2) frame(1, 2, 3, 4, 4);
    // Undecodable pattern on digit 1, then digit 0 commit with no frame
    repeat (3) step(1'b1, 4'b1101, 7'h7F);
    repeat (4) step(1'b1, 4'b1110, seg_tab[4]);
    // Glitch then long hold
    step(1'b1, 4'b1011, seg_tab[3]);
    repeat (10) step(1'b1, 4'b1011, seg_tab[5]);
    // Full frame then two anodes low until timeout
    frame(10, 11, 12, 13, 4);
    repeat (TIMEOUT + 20) step(1'b1, 4'b0011, seg_tab[8]);
    // Reset in the middle of a run
    frame(7, 6, 5, 4, 4);
    step(1'b1, 4'b1110, seg_tab[9]);
    step(1'b0, 4'b1110, seg_tab[9]);
    repeat (4) step(1'b1, 4'b1110, seg_tab[9]);
    // Random traffic
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0: an = 4'hF;
        1: begin
          a = $urandom_range(0, 3);
          b = (a + $urandom_range(1, 3)) % 4;
          an = ~((4'b0001 << a) | (4'b0001 << b));
        end
        default: an = ~(4'b0001 << $urandom_range(0, 3));
      endcase
      sg = ($urandom_range(0, 7) == 0) ? 7'($urandom) : seg_tab[$urandom_range(0, 15)];
      hold = $urandom_range(1, 5);
      if ($urandom_range(0, 59) == 0) step(1'b0, an, sg);
      repeat (hold) step(1'b1, an, sg);
    end
    repeat (2) frame(15, 0, 9, 14, 3);
    @(posedge disp_clk);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
